conv_fft_seq_ctrl: RTL and testbench
====================================

# conv_fft_seq_ctrl

Sequencer for the FFT convolution layer datapath: four 2-D FFT4 units feeding four image memory blocks, with an 8-way real/imag output select. It admits a job of `len` cachelines into the FFT path, counts completed memory writes, and reads every stored entry back eight times, select 0..7, into the output FIFO under backpressure. It sits between the job/context logic and the FFT datapath and replaces ad-hoc address and select handling with one job-level FSM.

## Interface
Parameters:
- `ADDR_W`, default 13: image memory address width. Maximum job length is 2^ADDR_W.
- `NUM_SEL`, default 8: select beats per entry (4 blocks × real/imag).
- `RD_LAT`, default 1: image memory read latency, in cycles, from address/select to data.

Ports:
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: job start pulse. Sampled only in IDLE.
- `ctx_length`, in, 32: job length in cachelines, latched on accepted `start`.
- `in_valid`, in, 1: upstream cacheline available.
- `in_ready`, out, 1: controller accepts a cacheline.
- `fft_next`, out, 1: `in_valid & in_ready`. Drives the FFT `next` / input_valid.
- `wr_strobe`, in, 1: one pulse per entry written to the image memories (the datapath `we`).
- `rd_address`, out, ADDR_W: image memory read address.
- `select`, out, 3: output mux select.
- `output_fifo_full`, in, 1: downstream FIFO cannot take RD_LAT more beats.
- `out_valid`, out, 1: `cacheline_out` holds a valid beat this cycle.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle job completion pulse.
- `err`, out, 1: sticky overflow flag. Cleared on accepted `start`.

## Operation
- States: IDLE, RUN, FLUSH.
- Internal registers:
  - `len`: ADDR_W+1 bits, equal to `min(ctx_length, 2^ADDR_W)`.
  - `in_cnt` and `wr_cnt`: ADDR_W+1 bits each.
  - `rd_addr`: ADDR_W+1 bits; `rd_address` is its low ADDR_W bits.
  - `sel`: 3 bits.
  - `vpipe`: RD_LAT-bit valid shift register.
- IDLE:
  - `start` latches `len` and clears `in_cnt`, `wr_cnt`, `rd_addr`, `sel` and `err`.
  - If `len` == 0: stay in IDLE and pulse `done` next cycle.
  - Otherwise go to RUN.
- RUN:
  - `in_ready` = (`in_cnt` < `len`). Each `fft_next` increments `in_cnt`.
  - `wr_strobe` increments `wr_cnt` while `wr_cnt` < `len`. Otherwise it sets `err` and `wr_cnt` holds.
  - Issue condition: `!output_fifo_full && rd_addr < wr_cnt`. Reads overlap loading.
  - On issue, push 1 into `vpipe`. If `sel` == NUM_SEL-1: `sel`←0 and `rd_addr`++. Otherwise `sel`++.
  - When the issue with `sel` == NUM_SEL-1 and `rd_addr` == `len`-1 occurs, go to FLUSH.
- FLUSH:
  - No issues and `in_ready` = 0.
  - After `vpipe` empties (RD_LAT cycles), go to IDLE with `done` = 1 for one cycle.
- Outside RUN, `wr_strobe` sets `err`.
- `out_valid` = `vpipe[RD_LAT-1]`.
- Each job produces exactly `NUM_SEL*len` beats, in order: address ascending, select 0..7 within each address.
- `start` outside IDLE is ignored, including in the `done` cycle. `start` one cycle after `done` is accepted.
- `output_fifo_full` only gates new issues. Beats already in `vpipe` always emerge.

## Timing
- Async reset: on `reset_n` low, all outputs and registers go to 0 immediately and the state goes to IDLE.
  - Reset mid-job abandons the job; there is no `done` pulse.
- Output types: `in_ready` and `fft_next` are combinational from state, counters and `in_valid`. All other outputs are registered.
- `start` at cycle 0 → RUN at cycle 1 → `in_ready` may assert at cycle 1.
- Issue at cycle t drives `rd_address`/`select` at t+1, with `out_valid` at t+1+RD_LAT-1. For RD_LAT = 1, `out_valid` is at t+1, aligned with the registered memory output.
- Throughput: 1 beat per cycle when unblocked and `wr_cnt` is ahead of `rd_addr`.
- Back-to-back jobs: minimum gap of 1 idle cycle.
- Simultaneous `wr_strobe` and an issue at `rd_addr` == `wr_cnt`: the issue uses the pre-increment `wr_cnt` and is not allowed that cycle.

## Test plan
- `len` = 2, `wr_strobe` 4 cycles after each `fft_next`, FIFO never full → `in_ready` drops after 2 accepts; 16 `out_valid` beats at (addr,sel) = (0,0)…(0,7),(1,0)…(1,7); single `done`; `err` = 0.
- `len` = 3, `output_fifo_full` high for 5 cycles after the 4th beat → no new issue while full; 24 total beats, no duplicates or gaps; `done` after the last beat + RD_LAT.
- `ctx_length` = 0 → `busy` never asserts, `in_ready` = 0, `done` at cycle 1, zero beats. `ctx_length` = 9000 → `len` clamped to 8192, i.e. 65536 beats.
- `len` = 1 with 2 `wr_strobe` pulses, plus one `wr_strobe` in IDLE → `err` = 1 and stays 1; `err` cleared on the next accepted `start`.
- `reset_n` pulsed low during RUN after 5 beats → all outputs 0 asynchronously, no `done`; a new `start` with `len` = 1 runs to 8 beats and `done`.
- First `wr_strobe` delayed 20 cycles after `fft_next` → no `out_valid` before strobe cycle + 1 + RD_LAT; `start` asserted during FLUSH is ignored.

Source files
------------

// File: rtl/conv_fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_fft_seq_ctrl
// Description : Job-level sequencer for the FFT convolution datapath: admits
//               cachelines, counts memory writes, replays entries x NUM_SEL.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_fft_seq_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int NUM_SEL = 8,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       ctx_length,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              fft_next,
    input  logic              wr_strobe,
    output logic [ADDR_W-1:0] rd_address,
    output logic [2:0]        select,
    input  logic              output_fifo_full,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] MAX_LEN  = 32'd1 << ADDR_W;
    localparam logic [2:0]  SEL_LAST = 3'(NUM_SEL - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   in_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_addr;
    logic [2:0]        sel;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] vpipe_nxt;
    logic [ADDR_W:0]   start_len;
    logic              accept;
    logic              issue;
    logic              flush_empty;

    assign start_len = (ctx_length > MAX_LEN) ? MAX_LEN[ADDR_W:0] : ctx_length[ADDR_W:0];
    assign in_ready  = (state == RUN) && (in_cnt < len);
    assign fft_next  = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign out_valid = vpipe[RD_LAT-1];

    // flush_empty: the pipe will be empty after this cycle's shift (no new issue in FLUSH)
    if (RD_LAT == 1) begin : g_lat1
        assign vpipe_nxt   = issue;
        assign flush_empty = 1'b1;
    end else begin : g_latn
        assign vpipe_nxt   = {vpipe[RD_LAT-2:0], issue};
        assign flush_empty = (vpipe[RD_LAT-2:0] == '0);
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                // the done cycle is still IDLE but must not take a new job
                if (start && !done) begin
                    accept = 1'b1;
                    if (start_len != '0)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                issue = !output_fifo_full && (rd_addr < wr_cnt);
                if (issue && (sel == SEL_LAST) && (rd_addr == len - 1'b1))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_empty)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            len        <= '0;
            in_cnt     <= '0;
            wr_cnt     <= '0;
            rd_addr    <= '0;
            sel        <= '0;
            vpipe      <= '0;
            rd_address <= '0;
            select     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            vpipe <= vpipe_nxt;
            done  <= 1'b0;
            if (accept) begin
                len     <= start_len;
                in_cnt  <= '0;
                wr_cnt  <= '0;
                rd_addr <= '0;
                sel     <= '0;
                err     <= 1'b0;
                if (start_len == '0)
                    done <= 1'b1;
            end
            if (fft_next)
                in_cnt <= in_cnt + 1'b1;
            if (wr_strobe) begin
                if ((state == RUN) && (wr_cnt < len))
                    wr_cnt <= wr_cnt + 1'b1;
                else
                    err <= 1'b1;
            end
            if (issue) begin
                rd_address <= rd_addr[ADDR_W-1:0];
                select     <= sel;
                if (sel == SEL_LAST) begin
                    sel     <= '0;
                    rd_addr <= rd_addr + 1'b1;
                end else begin
                    sel <= sel + 1'b1;
                end
            end
            if ((state == FLUSH) && flush_empty)
                done <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_fft_seq_ctrl
// Description : Directed self-checking bench for conv_fft_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_fft_seq_ctrl;
    localparam int ADDR_W = 13;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [31:0]       ctx_length;
    logic              in_valid;
    logic              in_ready;
    logic              fft_next;
    logic              wr_strobe;
    logic [ADDR_W-1:0] rd_address;
    logic [2:0]        select;
    logic              output_fifo_full;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              err;

    logic auto_strobe;
    logic man_strobe;
    assign wr_strobe = auto_strobe | man_strobe;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int beat_cnt = 0;
    int order_err = 0;
    int exp_addr = 0;
    int exp_sel = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cnt = 0;
    int strobe_cyc = 0;
    int delay = 4;
    int sched[$];

    conv_fft_seq_ctrl #(.ADDR_W(ADDR_W), .NUM_SEL(8), .RD_LAT(1)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .ctx_length       (ctx_length),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .fft_next         (fft_next),
        .wr_strobe        (wr_strobe),
        .rd_address       (rd_address),
        .select           (select),
        .output_fifo_full (output_fifo_full),
        .out_valid        (out_valid),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath stand-in: each accepted cacheline is written 'delay' cycles later
    always @(posedge clk) begin
        if (fft_next) begin
            acc_cnt++;
            sched.push_back(cyc + delay);
        end
        if (wr_strobe)
            strobe_cyc = cyc;
        cyc++;
    end

    always @(negedge clk) begin
        if (out_valid) begin
            if (rd_address !== exp_addr[ADDR_W-1:0] || select !== exp_sel[2:0])
                order_err++;
            if (exp_sel == 7) begin
                exp_sel = 0;
                exp_addr++;
            end else begin
                exp_sel++;
            end
            beat_cnt++;
            if (beat_cnt == 1)
                first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        auto_strobe = 1'b0;
        if (sched.size() > 0 && sched[0] == cyc) begin
            auto_strobe = 1'b1;
            void'(sched.pop_front());
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_job();
        beat_cnt  = 0;
        order_err = 0;
        exp_addr  = 0;
        exp_sel   = 0;
        acc_cnt   = 0;
    endtask

    task automatic start_job(input logic [31:0] ctx);
        tick();
        clear_job();
        ctx_length = ctx;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt != d0), 1);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (beat_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(beat_cnt >= target), 1);
    endtask

    initial begin
        int d0;
        reset_n          = 1'b0;
        start            = 1'b0;
        ctx_length       = '0;
        in_valid         = 1'b0;
        man_strobe       = 1'b0;
        auto_strobe      = 1'b0;
        output_fifo_full = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_rd_address", rd_address, 0);
        check("rst_select", select, 0);
        reset_n = 1'b1;
        tick();

        // len = 2, writes 4 cycles after each accept
        in_valid = 1'b1;
        delay    = 4;
        start_job(2);
        check("t1_busy", busy, 1);
        check("t1_in_ready_c1", in_ready, 1);
        tick();
        tick();
        check("t1_in_ready_drop", in_ready, 0);
        wait_done("t1_done", 200);
        check("t1_beats", beat_cnt, 16);
        check("t1_order", order_err, 0);
        check("t1_accepts", acc_cnt, 2);
        check("t1_err", err, 0);
        check("t1_done_gap", done_cyc - last_beat_cyc, 1);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_idle", busy, 0);

        // len = 3 with a 5-cycle FIFO stall after the 4th beat
        start_job(3);
        wait_beats("t2_reach4", 4, 200);
        output_fifo_full = 1'b1;
        repeat (5) tick();
        check("t2_stall", beat_cnt, 4);
        output_fifo_full = 1'b0;
        wait_done("t2_done", 300);
        check("t2_beats", beat_cnt, 24);
        check("t2_order", order_err, 0);
        check("t2_done_gap", done_cyc - last_beat_cyc, 1);

        // zero-length job; start held through the done cycle and one beyond
        tick();
        clear_job();
        ctx_length = 0;
        start      = 1'b1;
        tick();
        ctx_length = 1;
        check("t3_done_c1", done, 1);
        check("t3_busy_c1", busy, 0);
        check("t3_in_ready", in_ready, 0);
        tick();
        check("t3_ignored_in_done", busy, 0);
        check("t3_done_c2", done, 0);
        check("t3_no_beats", beat_cnt, 0);
        tick();
        start = 1'b0;
        check("t3_accept_after_done", busy, 1);
        wait_done("t3_len1_done", 200);
        check("t3_len1_beats", beat_cnt, 8);

        // clamp: 9000 -> 8192 entries
        delay = 1;
        start_job(9000);
        wait_done("t_clamp_done", 70000);
        check("t_clamp_beats", beat_cnt, 65536);
        check("t_clamp_order", order_err, 0);
        check("t_clamp_accepts", acc_cnt, 8192);
        check("t_clamp_err", err, 0);

        // overflow: two writes for a one-entry job
        delay = 4;
        start_job(1);
        tick();
        man_strobe = 1'b1;
        tick();
        man_strobe = 1'b0;
        wait_done("t4_done", 200);
        check("t4_err_overflow", err, 1);
        check("t4_beats", beat_cnt, 8);
        tick();
        man_strobe = 1'b1;
        tick();
        man_strobe = 1'b0;
        tick();
        check("t4_err_sticky", err, 1);
        start_job(1);
        check("t4_err_cleared", err, 0);
        wait_done("t4b_done", 200);
        check("t4b_err", err, 0);
        tick();
        man_strobe = 1'b1;
        tick();
        man_strobe = 1'b0;
        check("t4_err_idle_strobe", err, 1);

        // asynchronous reset mid-job
        start_job(2);
        wait_beats("t5_reach5", 5, 200);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_rd_address", rd_address, 0);
        check("t5_select", select, 0);
        check("t5_in_ready", in_ready, 0);
        check("t5_done", done, 0);
        d0 = done_cnt;
        sched.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_no_done", done_cnt, d0);
        start_job(1);
        wait_done("t5_restart_done", 200);
        check("t5_restart_beats", beat_cnt, 8);
        check("t5_restart_order", order_err, 0);

        // late write; start raised during FLUSH
        delay = 20;
        start_job(1);
        wait_beats("t6_reach8", 8, 300);
        ctx_length = 1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("t6_done", done, 1);
        check("t6_first_beat_lat", first_beat_cyc - strobe_cyc, 2);
        tick();
        tick();
        check("t6_flush_start_ignored", busy, 0);
        check("t6_beats", beat_cnt, 8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
